csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save (Wallace) reduction tree for the Kulisch accumulator datapath of the TensorCore SIMD unit.
- Reduces PARTIAL_COUNT operands of BW bits to a weight-correct sum/carry pair.
- Pipeline registers are inserted every REG_EVERY CSA levels.
- Valid/ready handshake with per-stage bubble collapsing, a sideband tag, and a synchronous flush.
- Sits between the partial-product generator and the final adder / Kulisch register.

Parameters:
- PARTIAL_COUNT, 6: number of input operands, ≥1.
- BW, 22: operand and result width; all arithmetic is modulo 2^BW.
- REG_EVERY, 1: CSA levels per pipeline register, ≥1.
- TAG_W, 4: sideband tag width, ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; invalidates all pipeline slots.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  PARTIAL_COUNT*BW  operands packed; operand k at [k*BW +: BW].
- in_tag  in  TAG_W  sideband tag, carried unchanged to the output.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output.
- out_sum  out  BW  sum vector.
- out_carry  out  BW  carry vector, already weight-aligned.
- out_tag  out  TAG_W  tag of the output item.

Behaviour:
- Reduction schedule per level: count n → (n/3)*2 + n%3.
- Operands are grouped in order: 3g, 3g+1, 3g+2. Leftover operands pass through at the highest indices.
- STAGES = number of levels until n ≤ 2. Equals 0 for PARTIAL_COUNT ≤ 2.
- Each CSA computes:
  - s = x^y^z
  - c = ((x&y)|(y&z)|(x&z)) << 1, MSB discarded.
- Invariant: out_sum + out_carry ≡ Σ operands (mod 2^BW).
- Final pair mapping:
  - n = 2: (p0, p1).
  - n = 1: (p0, 0).
- Pipeline registers:
  - NREG = max(1, ceil(STAGES/REG_EVERY)).
  - A register follows every REG_EVERY-th level; the last register drives the outputs directly.
  - Latency is NREG cycles from an accepted input to out_valid when there is no stall.
- Slot rules (slot i holds valid_i, data and tag):
  - advance_i = !valid_i || advance_{i+1}.
  - advance_last = !out_valid || out_ready.
  - in_ready = advance_0. in_ready is combinational from out_ready through the chain and never depends on in_valid.
- Slot i loads when advance_i is 1. Its valid becomes the upstream valid.
- Stall behaviour:
  - A full, stalled slot holds data and tag stable.
  - out_sum, out_carry and out_tag are held stable while out_valid && !out_ready.
- Bubbles collapse: an empty slot accepts data even if a later slot is stalled.
- Throughput is one item per cycle while out_ready = 1.
- flush:
  - Next edge clears all valid bits; data registers are not cleared.
  - An input presented in the same cycle is dropped, and in_ready is forced to 0 during flush.
  - flush takes priority over load.
- Reset (async assert, any time including mid-stream): all valids = 0, out_sum = 0, out_carry = 0, out_tag = 0, in_ready = 1 after reset. Items in flight are lost.
- Deassertion of rst_n is synchronised externally.
- No internal counters or overflow detection. Overflow wraps silently modulo 2^BW.

Optional Feature:
- CSA_TREE_FINAL_ADD_EN adds an extra output port out_result (BW) = out_sum + out_carry (mod 2^BW).
- out_result is registered in one extra slot with the same valid/ready and flush rules. Latency becomes NREG+1.
- out_sum and out_carry remain available and aligned with out_result.
- Without the macro, the port and slot are absent and latency is NREG.

Decomposition:
- Package csa_tree_pkg holds:
  - the constant function for STAGES (level count);
  - a function for NREG;
  - a function giving the operand count after level L, used for generate bounds.
- Sub-module csa3 (BW): combinational 3:2 compressor with the shifted carry. It is instantiated per group per level inside generate loops.
- Pipeline slots are generated in the top level. There is no separate FIFO.

Test Plan:
- PARTIAL_COUNT=6, BW=22, REG_EVERY=1: STAGES=3, NREG=3.
  - Operands 1,2,3,4,5,6, tag=5 → out_valid on 3rd edge after acceptance; out_sum+out_carry = 21; out_tag=5.
- Same configuration, all operands 0x3FFFFF → out_sum+out_carry mod 2^22 = 0x3FFFFA.
- Back-to-back stream of 8 items, out_ready low for cycles 4–7:
  - No item lost or duplicated; outputs stable while stalled.
  - in_ready drops only once all 3 slots are full; full rate resumes after release.
- PARTIAL_COUNT=2, REG_EVERY=2:
  - Latency 1; out_sum=in0, out_carry=in1 exactly.
  - With PARTIAL_COUNT=7, REG_EVERY=2: STAGES=4, latency 2.
- Assert rst_n low with 2 items in flight and out_ready=0 → out_valid=0 and outputs 0 immediately (asynchronous); next accepted item emerges correctly.
- flush pulse with 3 valid slots and in_valid=1 → out_valid=0 on the next cycle; the concurrent input is not accepted; the following input completes normally. With CSA_TREE_FINAL_ADD_EN, out_result = 21 for the first case at latency 4.

Source files
------------

// File: rtl/csa_tree_pkg.sv
// Elaboration-time helpers for the carry-save reduction schedule of csa_tree_pipe:
// operand count per level, number of CSA levels and number of pipeline registers.
package csa_tree_pkg;

  // Operand count left after 'levels' 3:2 reduction levels.
  function automatic int count_after(input int n0, input int levels);
    int n;
    n = n0;
    for (int l = 0; l < levels; l++) n = (n / 3) * 2 + n % 3;
    return n;
  endfunction

  function automatic int tree_stages(input int n0);
    int n;
    int s;
    n = n0;
    s = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + n % 3;
      s++;
    end
    return s;
  endfunction

  function automatic int tree_nreg(input int stages, input int reg_every);
    return (stages == 0) ? 1 : (stages + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_csa3.sv
// csa3: combinational 3:2 carry-save compressor; the carry is already shifted
// into its weight position and its MSB is dropped (arithmetic mod 2^BW).
module csa3 #(
  parameter int BW = 22
) (
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  input  logic [BW-1:0] z,
  output logic [BW-1:0] s,
  output logic [BW-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = ((x & y) | (y & z) | (x & z)) << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined Wallace reduction of PARTIAL_COUNT operands to a sum/carry
// pair with valid/ready slots and flush. Define CSA_TREE_FINAL_ADD_EN for out_result.
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int PARTIAL_COUNT = 6,
  parameter int BW            = 22,
  parameter int REG_EVERY     = 1,
  parameter int TAG_W         = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PARTIAL_COUNT*BW-1:0] in_data,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BW-1:0]               out_sum,
  output logic [BW-1:0]               out_carry,
  output logic [TAG_W-1:0]            out_tag
`ifdef CSA_TREE_FINAL_ADD_EN
  ,
  output logic [BW-1:0]               out_result
`endif
);

  localparam int STAGES = tree_stages(PARTIAL_COUNT);
  localparam int NREG   = tree_nreg(STAGES, REG_EVERY);
  localparam int NFINAL = count_after(PARTIAL_COUNT, STAGES);
`ifdef CSA_TREE_FINAL_ADD_EN
  localparam int NSLOT  = NREG + 1;
`else
  localparam int NSLOT  = NREG;
`endif

  logic [NSLOT-1:0] valid;
  logic [NSLOT-1:0] advance;
  logic [NSLOT-1:0] up_valid;
  logic [TAG_W-1:0] tag_q  [NSLOT];
  logic [TAG_W-1:0] up_tag [NSLOT];

  always_comb begin
    logic adv;
    // NOTE: advance gets a full default so no path through this block can infer a latch.
    advance = '0;
    // NOTE: blocking assignments here are deliberate: adv ripples from the output slot
    // toward the input within one evaluation, which is exactly the combinational chain.
    adv = out_ready;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      adv        = !valid[i] || adv;
      advance[i] = adv;
    end
  end

  assign up_valid = (valid << 1) | NSLOT'(in_valid);
  assign in_ready = advance[0] && !flush;
  assign out_valid = valid[NSLOT-1];
  assign out_tag   = tag_q[NSLOT-1];

  always_comb begin
    up_tag[0] = in_tag;
    for (int i = 1; i < NSLOT; i++) up_tag[i] = tag_q[i-1];
  end

  // NOTE: data registers are reset too, because the outputs must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NSLOT; i++) tag_q[i] <= '0;
    end else begin
      if (flush) valid <= '0;
      else       valid <= (advance & up_valid) | (~advance & valid);
      for (int i = 0; i < NSLOT; i++) begin
        if (advance[i]) tag_q[i] <= up_tag[i];
      end
    end
  end

  // lvl[l].node is the operand vector entering level l+1 (after its register, if any).
  for (genvar l = 0; l <= STAGES; l++) begin : lvl
    localparam int  N    = count_after(PARTIAL_COUNT, l);
    localparam bit  REG  = (l == 0) ? (STAGES == 0) : ((l % REG_EVERY == 0) || (l == STAGES));
    localparam int  SLOT = (l == 0) ? 0 : (l + REG_EVERY - 1) / REG_EVERY - 1;

    logic [N*BW-1:0] comb;
    logic [N*BW-1:0] node;

    if (l == 0) begin : g_src
      assign comb = in_data;
    end else begin : g_csa
      localparam int NP = count_after(PARTIAL_COUNT, l - 1);
      localparam int G  = NP / 3;
      for (genvar g = 0; g < G; g++) begin : grp
        csa3 #(.BW(BW)) u_csa (
          .x (lvl[l-1].node[(3*g)*BW   +: BW]),
          .y (lvl[l-1].node[(3*g+1)*BW +: BW]),
          .z (lvl[l-1].node[(3*g+2)*BW +: BW]),
          .s (comb[(2*g)*BW   +: BW]),
          .c (comb[(2*g+1)*BW +: BW])
        );
      end
      // Leftovers keep their order and sit above the compressed pairs.
      if (NP % 3 != 0) begin : g_pass
        assign comb[N*BW-1 : 2*G*BW] = lvl[l-1].node[NP*BW-1 : 3*G*BW];
      end
    end

    if (REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             node <= '0;
        else if (advance[SLOT]) node <= comb;
      end
    end else begin : g_wire
      assign node = comb;
    end
  end

  logic [BW-1:0] pair_sum;
  logic [BW-1:0] pair_carry;

  assign pair_sum = lvl[STAGES].node[BW-1:0];
  if (NFINAL >= 2) begin : g_pair2
    assign pair_carry = lvl[STAGES].node[2*BW-1:BW];
  end else begin : g_pair1
    assign pair_carry = '0;
  end

`ifdef CSA_TREE_FINAL_ADD_EN
  logic [BW-1:0] sum_q;
  logic [BW-1:0] carry_q;

  // Extra slot: the carry-propagate add, with the pair kept alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      carry_q    <= '0;
      out_result <= '0;
    end else if (advance[NSLOT-1]) begin
      sum_q      <= pair_sum;
      carry_q    <= pair_carry;
      out_result <= pair_sum + pair_carry;
    end
  end

  assign out_sum   = sum_q;
  assign out_carry = carry_q;
`else
  assign out_sum   = pair_sum;
  assign out_carry = pair_carry;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: directed vector table, stall/reset/flush
// sequences, randomized traffic against a queue-based reference model.
module tb_csa_tree_pipe;

  localparam int BW   = 22;
  localparam int PC   = 6;
  localparam int TW   = 4;
  localparam int MAXW = 7 * BW;
`ifdef CSA_TREE_FINAL_ADD_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT  = 3 + EXTRA;  // 6 operands, one level per register
  localparam int LAT2 = 1 + EXTRA;  // 2 operands, no CSA levels
  localparam int LAT3 = 2 + EXTRA;  // 7 operands, 4 levels, two levels per register

  typedef struct packed {
    logic [PC*BW-1:0] data;
    logic [TW-1:0]    tag;
    logic [BW-1:0]    exp_sum;
  } vec_t;

  typedef struct packed {
    logic [BW-1:0] sum;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC*BW-1:0] in_data;
  logic [TW-1:0]    in_tag, out_tag;
  logic [BW-1:0]    out_sum, out_carry;

  logic d2_in_valid, d2_in_ready, d2_out_valid;
  logic [2*BW-1:0] d2_in_data;
  logic [TW-1:0]   d2_in_tag, d2_out_tag;
  logic [BW-1:0]   d2_out_sum, d2_out_carry;

  logic d3_in_valid, d3_in_ready, d3_out_valid;
  logic [7*BW-1:0] d3_in_data;
  logic [TW-1:0]   d3_in_tag, d3_out_tag;
  logic [BW-1:0]   d3_out_sum, d3_out_carry;

`ifdef CSA_TREE_FINAL_ADD_EN
  logic [BW-1:0] out_result, d2_out_result, d3_out_result;
`endif

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;

  always #5 clk = ~clk;

  csa_tree_pipe #(.PARTIAL_COUNT(PC), .BW(BW), .REG_EVERY(1), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
`ifdef CSA_TREE_FINAL_ADD_EN
    , .out_result(out_result)
`endif
  );

  csa_tree_pipe #(.PARTIAL_COUNT(2), .BW(BW), .REG_EVERY(2), .TAG_W(TW)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .in_tag(d2_in_tag), .out_valid(d2_out_valid), .out_ready(1'b1),
    .out_sum(d2_out_sum), .out_carry(d2_out_carry), .out_tag(d2_out_tag)
`ifdef CSA_TREE_FINAL_ADD_EN
    , .out_result(d2_out_result)
`endif
  );

  csa_tree_pipe #(.PARTIAL_COUNT(7), .BW(BW), .REG_EVERY(2), .TAG_W(TW)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_data(d3_in_data), .in_tag(d3_in_tag), .out_valid(d3_out_valid), .out_ready(1'b1),
    .out_sum(d3_out_sum), .out_carry(d3_out_carry), .out_tag(d3_out_tag)
`ifdef CSA_TREE_FINAL_ADD_EN
    , .out_result(d3_out_result)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular sum of the first n operands.
  function automatic logic [BW-1:0] ref_sum(input logic [MAXW-1:0] d, input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < n; k++) acc += longint'(d[k*BW +: BW]);
    return BW'(acc);
  endfunction

  function automatic logic [PC*BW-1:0] pack6(input logic [BW-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Scoreboard of accepted items; also models in_ready and stall stability.
  exp_t sb[$];
  exp_t e;
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_sum, prev_carry;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_sum_held", out_sum, prev_sum);
        check("stall_carry_held", out_carry, prev_carry);
        check("stall_tag_held", out_tag, prev_tag);
      end
      check("in_ready_model", in_ready, !flush && !(sb.size() == LAT && !out_ready));
      if (out_valid && out_ready) begin
        out_cnt++;
        check("output_was_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_pair_sum", BW'(out_sum + out_carry), e.sum);
          check("sb_tag", out_tag, e.tag);
`ifdef CSA_TREE_FINAL_ADD_EN
          check("sb_result", out_result, e.sum);
`endif
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_sum   = out_sum;
      prev_carry = out_carry;
      prev_tag   = out_tag;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{sum: ref_sum(MAXW'(in_data), PC), tag: in_tag});
    end
  end

  task automatic run_single(input vec_t v);
    int lat;
    in_data = v.data; in_tag = v.tag; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("single_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("single_latency", lat, LAT);
    check("single_pair_sum", BW'(out_sum + out_carry), v.exp_sum);
    check("single_tag", out_tag, v.tag);
`ifdef CSA_TREE_FINAL_ADD_EN
    check("single_result", out_result, v.exp_sum);
`endif
    @(posedge clk); #1;
    check("single_drained", out_valid, 0);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    d2_in_valid = 1'b0; d2_in_data = '0; d2_in_tag = '0;
    d3_in_valid = 1'b0; d3_in_data = '0; d3_in_tag = '0;

    vecs[0] = '{data: pack6(22'd1, 22'd2, 22'd3, 22'd4, 22'd5, 22'd6), tag: 4'd5, exp_sum: 22'd21};
    vecs[1] = '{data: {PC{22'h3FFFFF}}, tag: 4'hA, exp_sum: 22'h3FFFFA};
    vecs[2] = '{data: '0, tag: 4'h0, exp_sum: 22'h0};
    vecs[3] = '{data: pack6(22'h155555, 22'h2AAAAA, 22'd1, 22'd0, 22'd0, 22'd0), tag: 4'hF, exp_sum: 22'h0};
    vecs[4] = '{data: {PC{22'h100000}}, tag: 4'd3, exp_sum: 22'h200000};
    vecs[5] = '{data: pack6(22'h200000, 22'h200000, 22'd7, 22'd0, 22'd0, 22'd0), tag: 4'd6, exp_sum: 22'd7};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_carry", out_carry, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_p2_out_valid", d2_out_valid, 0);
    check("reset_p7_out_valid", d3_out_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    // Back-to-back stream of 8 items with out_ready low during cycles 4..7.
    begin
      int sent, base;
      logic acc, saw_block;
      base = out_cnt; sent = 0; saw_block = 1'b0;
      for (int c = 0; c < 60 && !(sent == 8 && sb.size() == 0); c++) begin
        out_ready = !(c >= 4 && c <= 7);
        in_valid  = (sent < 8);
        for (int k = 0; k < PC; k++) in_data[k*BW +: BW] = BW'(sent * 1000 + k * 32'h55555);
        in_tag = TW'(sent);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (!in_ready) saw_block = 1'b1;
        @(posedge clk); #1;
        if (acc) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_items_out", out_cnt - base, 8);
      check("stream_sb_empty", sb.size(), 0);
      check("stream_backpressure_seen", saw_block, 1);
    end

    // Asynchronous reset with two items in flight and the output stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[1].data; in_tag = 4'd3;
    @(posedge clk); #1;
    in_tag = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_out_sum", out_sum, 0);
    check("async_reset_out_carry", out_carry, 0);
    check("async_reset_out_tag", out_tag, 0);
    check("async_reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_single(vecs[0]);

    // Flush with three valid slots and a concurrent input.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vecs[i+1].data; in_tag = vecs[i+1].tag;
      @(posedge clk); #1;
    end
    flush = 1'b1; in_data = {PC{22'd9}}; in_tag = 4'hE;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      @(posedge clk); #1;
      check("flush_no_output", out_valid, 0);
    end
    run_single(vecs[0]);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
      for (int k = 0; k < PC; k++)
        in_data[k*BW +: BW] = (($urandom % 5) == 0) ? {BW{1'b1}} : BW'($urandom);
      in_tag = TW'($urandom);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("random_sb_drained", sb.size(), 0);
    check("random_out_idle", out_valid, 0);

    // Other configurations: 2 operands (pass-through pair) and 7 operands.
    for (int i = 0; i < 4; i++) begin
      int lat2, lat3;
      for (int k = 0; k < 2; k++) d2_in_data[k*BW +: BW] = BW'($urandom);
      for (int k = 0; k < 7; k++) d3_in_data[k*BW +: BW] = (i == 0) ? {BW{1'b1}} : BW'($urandom);
      d2_in_tag = TW'(i); d3_in_tag = TW'(i + 8);
      d2_in_valid = 1'b1; d3_in_valid = 1'b1;
      @(posedge clk); #1;
      d2_in_valid = 1'b0; d3_in_valid = 1'b0;
      lat2 = 0; lat3 = 0;
      for (int t = 1; t <= 8; t++) begin
        if (d2_out_valid && lat2 == 0) begin
          lat2 = t;
          check("p2_sum_is_in0", d2_out_sum, d2_in_data[BW-1:0]);
          check("p2_carry_is_in1", d2_out_carry, d2_in_data[2*BW-1:BW]);
          check("p2_tag", d2_out_tag, d2_in_tag);
`ifdef CSA_TREE_FINAL_ADD_EN
          check("p2_result", d2_out_result, ref_sum(MAXW'(d2_in_data), 2));
`endif
        end
        if (d3_out_valid && lat3 == 0) begin
          lat3 = t;
          check("p7_pair_sum", BW'(d3_out_sum + d3_out_carry), ref_sum(d3_in_data, 7));
          check("p7_tag", d3_out_tag, d3_in_tag);
`ifdef CSA_TREE_FINAL_ADD_EN
          check("p7_result", d3_out_result, ref_sum(d3_in_data, 7));
`endif
        end
        @(posedge clk); #1;
      end
      check("p2_latency", lat2, LAT2);
      check("p7_latency", lat3, LAT3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
